// File: rtl/scan_mux_nto1_pkg.sv
// rtl/scan_mux_nto1_pkg.sv - shared mode encodings and width helper for the lab display blocks
package scan_mux_nto1_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Bits needed to index n values, never less than one so a degenerate count still gets a register.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - free-running dwell counter that pulses tick on its last count
module dwell_timer
  import scan_mux_nto1_pkg::*;
#(
  parameter int DWELL = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = clog2_min1(DWELL);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt;

  // tick is combinational so the owner can advance on the same edge that wraps the count.
  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/scan_mux_nto1.sv
// rtl/scan_mux_nto1.sv - N-channel registered selector with manual select or timed auto-scan
module scan_mux_nto1
  import scan_mux_nto1_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 50000000,
  localparam int SEL_W   = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      hold,
  input  logic [SEL_W-1:0]          s,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [WIDTH-1:0]          m,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      wrap
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic             mode_q;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] s_clamp;
  logic [SEL_W-1:0] sel_eff;
  logic [WIDTH-1:0] m_next;
  logic             entry;
  logic             timer_en;
  logic             timer_clr;
  logic             advance;

  assign s_clamp = (int'(s) >= CHANNELS) ? LAST_CH : s;
  assign entry   = (mode == MODE_SCAN) && (mode_q == MODE_MANUAL);

  assign timer_en  = (mode == MODE_SCAN) && !hold;
  assign timer_clr = entry || (mode == MODE_MANUAL);

  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell_timer (
    .clk (clk),
    .rst (rst),
    .en  (timer_en),
    .clr (timer_clr),
    .tick(advance)
  );

  // On the entry cycle the pointer is still stale, so show clamped s to avoid a one-cycle glitch.
  assign sel_eff = ((mode == MODE_MANUAL) || entry) ? s_clamp : ptr;

  always_comb begin
    m_next = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_eff == SEL_W'(k)) begin
        m_next = d[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_SCAN;
      ptr     <= '0;
      m       <= '0;
      cur_sel <= '0;
      wrap    <= 1'b0;
    end else begin
      mode_q  <= mode;
      m       <= m_next;
      cur_sel <= sel_eff;
      wrap    <= advance && (ptr == LAST_CH);
      if (entry) begin
        ptr <= s_clamp;
      end else if (advance) begin
        ptr <= (ptr == LAST_CH) ? '0 : ptr + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_scan_mux_nto1.sv
// tb/tb_scan_mux_nto1.sv - directed self-checking bench for scan_mux_nto1
module tb_scan_mux_nto1;

  localparam logic [7:0] D4 = 8'b11_10_01_00;
  localparam logic [7:0] D4_CH1_ALT = 8'b11_10_10_00;
  localparam logic [5:0] D3 = 6'b10_01_00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst, mode, hold;
  logic [1:0] s;
  logic [7:0] d;
  logic [1:0] m;
  logic [1:0] cur_sel;
  logic       wrap;

  logic       rst_b, mode_b, hold_b;
  logic [1:0] s_b;
  logic [5:0] d_b;
  logic [1:0] m_b;
  logic [1:0] cur_sel_b;
  logic       wrap_b;

  scan_mux_nto1 #(.WIDTH(2), .CHANNELS(4), .DWELL(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .hold(hold), .s(s), .d(d),
    .m(m), .cur_sel(cur_sel), .wrap(wrap)
  );

  scan_mux_nto1 #(.WIDTH(2), .CHANNELS(3), .DWELL(4)) dut3 (
    .clk(clk), .rst(rst_b), .mode(mode_b), .hold(hold_b), .s(s_b), .d(d_b),
    .m(m_b), .cur_sel(cur_sel_b), .wrap(wrap_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; hold = 1'b0; s = 2'd3; d = D4;
    step();
    checks++; if (m !== 2'd0) begin errors++; $display("FAIL reset_m: got %0d expected 0", m); end
    checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL reset_cur_sel: got %0d expected 0", cur_sel); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %0d expected 0", wrap); end
  endtask

  task automatic test_manual();
    rst = 1'b0; mode = 1'b0; hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      step();
      checks++; if (cur_sel !== 2'(i)) begin errors++; $display("FAIL manual_cur_sel[%0d]: got %0d expected %0d", i, cur_sel, i); end
      checks++; if (m !== 2'(i)) begin errors++; $display("FAIL manual_m[%0d]: got %0d expected %0d", i, m, i); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL manual_wrap[%0d]: got %0d expected 0", i, wrap); end
    end
    rst = 1'b1;
    step();
    checks++; if (m !== 2'd0) begin errors++; $display("FAIL manual_rst_m: got %0d expected 0", m); end
    checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL manual_rst_cur_sel: got %0d expected 0", cur_sel); end
    rst = 1'b0; hold = 1'b0;
  endtask

  task automatic test_scan_wrap();
    logic [1:0] exp_sel;
    logic       exp_wrap;
    rst = 1'b1; mode = 1'b1; hold = 1'b0; d = D4;
    step();
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      exp_sel  = 2'(((c - 1) / 4) % 4);
      exp_wrap = (c == 16);
      checks++; if (cur_sel !== exp_sel) begin errors++; $display("FAIL scan_cur_sel[%0d]: got %0d expected %0d", c, cur_sel, exp_sel); end
      checks++; if (m !== exp_sel) begin errors++; $display("FAIL scan_m[%0d]: got %0d expected %0d", c, m, exp_sel); end
      checks++; if (wrap !== exp_wrap) begin errors++; $display("FAIL scan_wrap[%0d]: got %0d expected %0d", c, wrap, exp_wrap); end
    end
  endtask

  task automatic test_hold();
    logic [1:0] exp_m;
    rst = 1'b1; mode = 1'b1; hold = 1'b0; d = D4;
    step();
    rst = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL hold_pre_sel[%0d]: got %0d expected 1", i, cur_sel); end
    end
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) d = D4_CH1_ALT;
      step();
      exp_m = (i >= 2) ? 2'b10 : 2'b01;
      checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL hold_sel[%0d]: got %0d expected 1", i, cur_sel); end
      checks++; if (m !== exp_m) begin errors++; $display("FAIL hold_m[%0d]: got %0d expected %0d", i, m, exp_m); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap[%0d]: got %0d expected 0", i, wrap); end
    end
    hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL hold_post_sel[%0d]: got %0d expected 1", i, cur_sel); end
    end
    step();
    checks++; if (cur_sel !== 2'd2) begin errors++; $display("FAIL hold_advance_sel: got %0d expected 2", cur_sel); end
    checks++; if (m !== 2'b10) begin errors++; $display("FAIL hold_advance_m: got %0d expected 2", m); end
    d = D4;
  endtask

  task automatic test_mode_handoff();
    rst = 1'b1; mode = 1'b0; hold = 1'b0; s = 2'd2; d = D4;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (cur_sel !== 2'd2) begin errors++; $display("FAIL handoff_manual[%0d]: got %0d expected 2", i, cur_sel); end
    end
    mode = 1'b1;
    step();
    checks++; if (cur_sel !== 2'd2) begin errors++; $display("FAIL handoff_entry: got %0d expected 2", cur_sel); end
    s = 2'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (cur_sel !== 2'd2) begin errors++; $display("FAIL handoff_dwell[%0d]: got %0d expected 2", i, cur_sel); end
    end
    step();
    checks++; if (cur_sel !== 2'd3) begin errors++; $display("FAIL handoff_next: got %0d expected 3", cur_sel); end
    checks++; if (m !== 2'd3) begin errors++; $display("FAIL handoff_next_m: got %0d expected 3", m); end
    mode = 1'b0; s = 2'd1;
    step();
    checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL handoff_exit: got %0d expected 1", cur_sel); end
    checks++; if (m !== 2'd1) begin errors++; $display("FAIL handoff_exit_m: got %0d expected 1", m); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL handoff_exit_wrap: got %0d expected 0", wrap); end
  endtask

  task automatic test_reset_mid_scan();
    rst = 1'b1; mode = 1'b1; hold = 1'b0; d = D4;
    step();
    rst = 1'b0;
    repeat (14) step();
    checks++; if (cur_sel !== 2'd3) begin errors++; $display("FAIL midrst_pre: got %0d expected 3", cur_sel); end
    rst = 1'b1;
    step();
    checks++; if (m !== 2'd0) begin errors++; $display("FAIL midrst_m: got %0d expected 0", m); end
    checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL midrst_sel: got %0d expected 0", cur_sel); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL midrst_wrap: got %0d expected 0", wrap); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (cur_sel !== 2'd0) begin errors++; $display("FAIL midrst_hold0[%0d]: got %0d expected 0", i, cur_sel); end
    end
    step();
    checks++; if (cur_sel !== 2'd1) begin errors++; $display("FAIL midrst_next: got %0d expected 1", cur_sel); end
  endtask

  task automatic test_clamp();
    logic [1:0] exp_sel;
    logic       exp_wrap;
    rst_b = 1'b1; mode_b = 1'b0; hold_b = 1'b0; s_b = 2'd3; d_b = D3;
    step();
    rst_b = 1'b0;
    step();
    checks++; if (cur_sel_b !== 2'd2) begin errors++; $display("FAIL clamp_sel: got %0d expected 2", cur_sel_b); end
    checks++; if (m_b !== 2'b10) begin errors++; $display("FAIL clamp_m: got %0d expected 2", m_b); end
    s_b = 2'd1;
    step();
    checks++; if (cur_sel_b !== 2'd1) begin errors++; $display("FAIL clamp_s1: got %0d expected 1", cur_sel_b); end
    rst_b = 1'b1; mode_b = 1'b1;
    step();
    rst_b = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      step();
      exp_sel  = 2'(((c - 1) / 4) % 3);
      exp_wrap = (c == 12);
      checks++; if (cur_sel_b !== exp_sel) begin errors++; $display("FAIL clamp_scan_sel[%0d]: got %0d expected %0d", c, cur_sel_b, exp_sel); end
      checks++; if (wrap_b !== exp_wrap) begin errors++; $display("FAIL clamp_scan_wrap[%0d]: got %0d expected %0d", c, wrap_b, exp_wrap); end
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; hold = 1'b0; s = 2'd0; d = D4;
    rst_b = 1'b1; mode_b = 1'b0; hold_b = 1'b0; s_b = 2'd0; d_b = D3;
    test_reset();
    test_manual();
    test_scan_wrap();
    test_hold();
    test_mode_handoff();
    test_reset_mid_scan();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
